// File: rtl/nco_pkg.sv
// Shared constants and types for the I/Q numerically controlled oscillator.
package nco_pkg;
  localparam int NCO_LAT = 3;
  typedef enum logic [1:0] {QUAD_0, QUAD_1, QUAD_2, QUAD_3} quad_e;
endpackage

// File: rtl/idx_to_qsin_addr.sv
// Folds a full-cycle table index into a quarter-sine address plus quadrant.
module idx_to_qsin_addr
  import nco_pkg::*;
#(
  parameter int ABITS = 10
) (
  input  logic [ABITS-1:0] idx,
  output logic [ABITS-3:0] addr,
  output quad_e            quad,
  output logic             peak
);
  logic [ABITS-3:0] frac;
  logic             mirror;

  assign frac   = idx[ABITS-3:0];
  assign mirror = idx[ABITS-2];
  assign quad   = quad_e'(idx[ABITS-1:ABITS-2]);
  assign addr   = mirror ? -frac : frac;
  // The mirrored point at frac==0 lands one past the table end: the peak.
  assign peak   = mirror && (frac == '0);
endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator with tuning-word register, clear/load handling and phase offset.
module nco_phase_acc #(
  parameter int PW = 32,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] ftw,
  input  logic          ftw_load,
  input  logic [PW-1:0] phase_off,
  input  logic          phase_clr,
  input  logic          next_sample,
  output logic [OW-1:0] phase,
  output logic          phase_valid,
  output logic [PW-1:0] acc
);
  logic [PW-1:0] acc_reg;
  logic [PW-1:0] ftw_reg;
  logic [PW-1:0] base;
  logic [PW-1:0] sample_phase;

  // A clear takes effect before both the lookup and the step of the same cycle.
  assign base         = phase_clr ? '0 : acc_reg;
  assign sample_phase = base + phase_off;
  assign phase        = sample_phase[PW-1 -: OW];
  assign phase_valid  = next_sample;
  assign acc          = acc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
      ftw_reg <= '0;
    end else begin
      if (ftw_load) ftw_reg <= ftw;
      if (phase_clr || next_sample) acc_reg <= base + (next_sample ? ftw_reg : '0);
    end
  end
endmodule

// File: rtl/qsin_lut_2p.sv
// Dual-read quarter-sine ROM with registered outputs; contents built at elaboration.
module qsin_lut_2p #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int SCALE = 2**(DW-1)-1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2
);
  localparam int  DEPTH   = 2**AW;
  localparam real HALF_PI = 1.5707963267948966;

  logic [DW-1:0] rom [DEPTH];

  // Taylor series keeps the table free of tool-specific math builtins.
  function automatic logic [DW-1:0] qsin(input int k);
    real x;
    real term;
    real sum;
    x    = HALF_PI * k / DEPTH;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return DW'($rtoi(sum * SCALE + 0.5));
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = qsin(gi);
  end

  always_ff @(posedge clk) begin
    data1 <= rom[addr1];
    data2 <= rom[addr2];
  end
endmodule

// File: rtl/qsin_to_sin.sv
// Rebuilds a signed sine sample from a quarter-table magnitude and quadrant.
module qsin_to_sin
  import nco_pkg::*;
#(
  parameter int DW    = 16,
  parameter int SCALE = 2**(DW-1)-1
) (
  input  logic [DW-1:0]        mag,
  input  quad_e                quad,
  input  logic                 peak,
  input  logic                 neg,
  output logic signed [DW-1:0] sample
);
  logic signed [DW-1:0] m;
  logic signed [DW-1:0] s;

  always_comb begin
    m      = peak ? DW'(SCALE) : mag;
    s      = (quad == QUAD_2 || quad == QUAD_3) ? -m : m;
    sample = neg ? -s : s;
  end
endmodule

// File: rtl/iq_nco.sv
// Programmable I/Q NCO: phase accumulator -> quarter-sine lookup -> signed I/Q, latency 3.
module iq_nco
  import nco_pkg::*;
#(
  parameter int DW    = 16,
  parameter int PW    = 32,
  parameter int ABITS = 10,
  parameter int SCALE = 2**(DW-1)-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] ftw,
  input  logic          ftw_load,
  input  logic [PW-1:0] phase_off,
  input  logic          phase_clr,
  input  logic          q_neg,
  input  logic          next_sample,
  output logic [DW-1:0] inphase_sample,
  output logic [DW-1:0] quadrature_sample,
  output logic          out_valid,
  output logic [PW-1:0] phase_out
);
  localparam int AW = ABITS - 2;

  logic [ABITS-1:0]     q_idx;
  logic                 phase_valid;
  logic [ABITS-1:0]     idx        [2];
  logic [AW-1:0]        addr_c     [2];
  quad_e                quad_c     [2];
  logic                 peak_c     [2];
  logic [AW-1:0]        addr_s1    [2];
  quad_e                quad_s1    [2];
  logic                 peak_s1    [2];
  quad_e                quad_s2    [2];
  logic                 peak_s2    [2];
  logic [DW-1:0]        lut_d      [2];
  logic signed [DW-1:0] sample_c   [2];
  logic signed [DW-1:0] sample_reg [2];
  logic                 neg_s1;
  logic                 neg_s2;
  logic [NCO_LAT-1:0]   valid_pipe;

  nco_phase_acc #(.PW(PW), .OW(ABITS)) u_acc (
    .clk(clk), .rst(rst), .ftw(ftw), .ftw_load(ftw_load), .phase_off(phase_off),
    .phase_clr(phase_clr), .next_sample(next_sample), .phase(q_idx),
    .phase_valid(phase_valid), .acc(phase_out)
  );

  // Lane 0 is I (cos = sin shifted a quarter cycle ahead), lane 1 is Q.
  assign idx[0] = q_idx + ABITS'(2**(ABITS-2));
  assign idx[1] = q_idx;

  qsin_lut_2p #(.DW(DW), .AW(AW), .SCALE(SCALE)) u_lut (
    .clk(clk), .addr1(addr_s1[0]), .addr2(addr_s1[1]), .data1(lut_d[0]), .data2(lut_d[1])
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    idx_to_qsin_addr #(.ABITS(ABITS)) u_addr (
      .idx(idx[gi]), .addr(addr_c[gi]), .quad(quad_c[gi]), .peak(peak_c[gi])
    );
    qsin_to_sin #(.DW(DW), .SCALE(SCALE)) u_sin (
      .mag(lut_d[gi]), .quad(quad_s2[gi]), .peak(peak_s2[gi]),
      .neg(gi == 1 ? neg_s2 : 1'b0), .sample(sample_c[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_pipe <= '0;
      neg_s1     <= 1'b0;
      neg_s2     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_s1[i]    <= '0;
        quad_s1[i]    <= QUAD_0;
        peak_s1[i]    <= 1'b0;
        quad_s2[i]    <= QUAD_0;
        peak_s2[i]    <= 1'b0;
        sample_reg[i] <= '0;
      end
    end else begin
      valid_pipe <= {valid_pipe[NCO_LAT-2:0], phase_valid};
      neg_s1     <= q_neg;
      neg_s2     <= neg_s1;
      for (int i = 0; i < 2; i++) begin
        addr_s1[i] <= addr_c[i];
        quad_s1[i] <= quad_c[i];
        peak_s1[i] <= peak_c[i];
        quad_s2[i] <= quad_s1[i];
        peak_s2[i] <= peak_s1[i];
        // Outputs only move on a valid sample and hold otherwise.
        if (valid_pipe[NCO_LAT-2]) sample_reg[i] <= sample_c[i];
      end
    end
  end

  assign out_valid         = valid_pipe[NCO_LAT-1];
  assign inphase_sample    = sample_reg[0];
  assign quadrature_sample = sample_reg[1];
endmodule

// File: tb/tb_iq_nco.sv
// Self-checking bench for iq_nco: trig-based reference model plus directed literal checks.
module tb_iq_nco;
  localparam int  DW = 16, PW = 32, ABITS = 10, SCALE = 32767, NIDX = 1024;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst, ftw_load, phase_clr, q_neg, next_sample;
  logic [PW-1:0] ftw, phase_off;
  logic [DW-1:0] inphase_sample, quadrature_sample;
  logic          out_valid;
  logic [PW-1:0] phase_out;

  iq_nco #(.DW(DW), .PW(PW), .ABITS(ABITS), .SCALE(SCALE)) dut (
    .clk(clk), .rst(rst), .ftw(ftw), .ftw_load(ftw_load), .phase_off(phase_off),
    .phase_clr(phase_clr), .q_neg(q_neg), .next_sample(next_sample),
    .inphase_sample(inphase_sample), .quadrature_sample(quadrature_sample),
    .out_valid(out_valid), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int i; int q;} exp_t;
  exp_t          exp_q[$];
  int            got_i[$], got_q[$];
  int            checks = 0, errors = 0;
  int            m_edge = 0, last_i = 0, last_q = 0;
  logic [PW-1:0] m_acc = '0, m_ftw = '0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
  function automatic int model_cos(input int k);
    return rnd(SCALE * $cos(2.0 * PI * k / NIDX));
  endfunction
  function automatic int model_sin(input int k);
    return rnd(SCALE * $sin(2.0 * PI * k / NIDX));
  endfunction
  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Advance the reference by one rising edge using the inputs it is about to sample.
  task automatic model_step();
    logic [PW-1:0] base;
    int            k;
    exp_t          e;
    m_edge++;
    if (!rst) begin
      m_acc = '0;
      m_ftw = '0;
      exp_q.delete();
      last_i = 0;
      last_q = 0;
    end else begin
      base = phase_clr ? '0 : m_acc;
      if (next_sample) begin
        k     = int'((base + phase_off) >> (PW - ABITS));
        e.due = m_edge + 2;
        e.i   = model_cos(k);
        e.q   = q_neg ? -model_sin(k) : model_sin(k);
        exp_q.push_back(e);
        m_acc = base + m_ftw;
      end else begin
        m_acc = base;
      end
      if (ftw_load) m_ftw = ftw;
    end
  endtask

  task automatic compare();
    int di, dq;
    bit exp_v;
    di    = int'($signed(inphase_sample));
    dq    = int'($signed(quadrature_sample));
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == m_edge);
    if (exp_v) begin
      last_i = exp_q[0].i;
      last_q = exp_q[0].q;
      void'(exp_q.pop_front());
    end
    chk("out_valid", out_valid === exp_v, longint'(out_valid), longint'(exp_v));
    if (out_valid === 1'b1) begin
      got_i.push_back(di);
      got_q.push_back(dq);
    end
    chk("i_sample", !$isunknown(inphase_sample) && absd(di, last_i) <= 1, di, last_i);
    chk("q_sample", !$isunknown(quadrature_sample) && absd(dq, last_q) <= 1, dq, last_q);
    chk("phase_out", phase_out === m_acc, phase_out, m_acc);
  endtask

  initial begin
    #1;
    model_step();
    forever begin
      @(negedge clk);
      compare();
      model_step();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_count(input string name, input int n);
    chk({name, "_count"}, got_i.size() == n, got_i.size(), n);
  endtask

  task automatic check_at(input string name, input int idx, input int ei, input int eq);
    if (got_i.size() <= idx) begin
      chk({name, "_missing"}, 1'b0, got_i.size(), idx + 1);
    end else begin
      chk({name, "_i"}, absd(got_i[idx], ei) <= 1, got_i[idx], ei);
      chk({name, "_q"}, absd(got_q[idx], eq) <= 1, got_q[idx], eq);
    end
  endtask

  task automatic clear_got();
    got_i.delete();
    got_q.delete();
  endtask

  task automatic strobes(input int n);
    next_sample = 1'b1;
    tick(n);
    next_sample = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ftw = '0; phase_off = '0; ftw_load = 1'b0;
    phase_clr = 1'b0; q_neg = 1'b0; next_sample = 1'b1;
    chk("model_cos0", model_cos(0) == SCALE, model_cos(0), SCALE);
    chk("model_sin768", model_sin(768) == -SCALE, model_sin(768), -SCALE);

    // 1: reset held with strobes
    tick(4);
    chk("t1_valid", out_valid === 1'b0, out_valid, 0);
    chk("t1_phase", phase_out === '0, phase_out, 0);

    // 2: quarter-cycle step, four back-to-back strobes
    rst = 1'b1; next_sample = 1'b0; ftw = 32'h4000_0000; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    clear_got();
    strobes(4);
    tick(4);
    check_count("t2", 4);
    check_at("t2_s0", 0, SCALE, 0);
    check_at("t2_s1", 1, 0, SCALE);
    check_at("t2_s2", 2, -SCALE, 0);
    check_at("t2_s3", 3, 0, -SCALE);

    // 3: same with lagging Q
    q_neg = 1'b1;
    clear_got();
    strobes(4);
    q_neg = 1'b0;
    tick(4);
    check_count("t3", 4);
    check_at("t3_s1", 1, 0, -SCALE);
    check_at("t3_s3", 3, 0, SCALE);

    // 4: half-cycle step, then clear together with strobe
    ftw = 32'h8000_0000; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    clear_got();
    strobes(3);
    phase_clr = 1'b1;
    strobes(1);
    phase_clr = 1'b0;
    chk("t4_phase", phase_out === 32'h8000_0000, phase_out, 32'h8000_0000);
    tick(4);
    check_count("t4", 4);
    check_at("t4_s1", 1, -SCALE, 0);
    check_at("t4_clr", 3, SCALE, 0);

    // 5: load coincident with strobe uses the old step
    clear_got();
    ftw = 32'h2000_0000; ftw_load = 1'b1;
    strobes(1);
    ftw_load = 1'b0;
    chk("t5_old_step", phase_out === 32'h0000_0000, phase_out, 0);
    phase_off = 32'h4000_0000;
    strobes(1);
    phase_off = '0;
    chk("t5_new_step", phase_out === 32'h2000_0000, phase_out, 32'h2000_0000);
    tick(4);
    check_count("t5", 2);
    check_at("t5_s0", 0, -SCALE, 0);
    check_at("t5_off", 1, 0, SCALE);
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    chk("t5_clr_only", phase_out === '0, phase_out, 0);

    // 6: reset pulse while two samples are in flight
    strobes(2);
    clear_got();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(5);
    check_count("t6_flushed", 0);
    strobes(2);
    tick(4);
    check_count("t6", 2);
    check_at("t6_s0", 0, SCALE, 0);
    check_at("t6_s1", 1, SCALE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
